// File: rtl/if_id_stage.sv
// ---------------------------------------------------------------------------
// if_id_stage
//
// IF/ID pipeline register with load-use hazard detection and wrong-path
// squashing. It latches the fetched instruction and its PC+4, exposes the
// decode fields as wired slices, and drives the PC-hold and ID/EXE bubble
// controls.
//
// Parameters:
//   FLUSH_CYCLES  IF/ID slots squashed after a taken branch/jump (1..3)
//
// Ports:
//   clk, rst_n                 clock, async active-low reset
//   InstrIn, PCplus4In         fetched instruction and its PC+4
//   ID_EXE_MemRead/RtAddr      load currently in EXE and its destination
//   BranchTaken, JumpTaken     control-flow redirect this cycle
//   IF_ID_*                    latched instruction, PC+4, decode fields
//   IF_ID_Valid                latched instruction is on the correct path
//   PCWrite                    0 = hold the PC
//   Bubble                     1 = zero all ID/EXE control inputs
//   StallCount, FlushCount     only when HAZARD_STATS_EN is defined
//
// Build option: define HAZARD_STATS_EN to add the saturating stall/flush
// event counters.
// ---------------------------------------------------------------------------
module if_id_stage #(
  parameter int unsigned FLUSH_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] InstrIn,
  input  logic [31:0] PCplus4In,
  input  logic        ID_EXE_MemRead,
  input  logic [4:0]  ID_EXE_RtAddr,
  input  logic        BranchTaken,
  input  logic        JumpTaken,
  output logic [31:0] IF_ID_Instr,
  output logic [31:0] IF_ID_PCplus4,
  output logic [5:0]  IF_ID_Opcode,
  output logic [4:0]  IF_ID_RsAddr,
  output logic [4:0]  IF_ID_RtAddr,
  output logic [4:0]  IF_ID_Rd,
  output logic [4:0]  IF_ID_Shamt,
  output logic [5:0]  IF_ID_Func,
  output logic [15:0] IF_ID_Imm,
  output logic        IF_ID_Valid,
  output logic        PCWrite,
  output logic        Bubble
`ifdef HAZARD_STATS_EN
  ,
  output logic [31:0] StallCount,
  output logic [31:0] FlushCount
`endif
);

  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_LDSTALL = 2'd1,
    ST_FLUSH   = 2'd2
  } state_e;

  // The flushing edge itself squashes one slot; the FLUSH state covers the
  // remaining FLUSH_CYCLES-1 slots, so a single-cycle flush never enters it.
  localparam logic [1:0] CNT_LOAD = 2'(FLUSH_CYCLES - 1);

  localparam logic [5:0] OP_RTYPE = 6'd0;
  localparam logic [5:0] OP_BEQ   = 6'd4;
  localparam logic [5:0] OP_BNE   = 6'd5;
  localparam logic [5:0] OP_SW    = 6'd43;

  state_e      state_q, state_d;
  logic [1:0]  cnt_q, cnt_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] pcplus4_q, pcplus4_d;
  logic        valid_q, valid_d;

  logic flush;
  logic uses_rt;
  logic hazard;
  logic stall_run;

  // Decode fields are pure slices of the latched instruction.
  assign IF_ID_Instr   = instr_q;
  assign IF_ID_PCplus4 = pcplus4_q;
  assign IF_ID_Valid   = valid_q;
  assign IF_ID_Opcode  = instr_q[31:26];
  assign IF_ID_RsAddr  = instr_q[25:21];
  assign IF_ID_RtAddr  = instr_q[20:16];
  assign IF_ID_Rd      = instr_q[15:11];
  assign IF_ID_Shamt   = instr_q[10:6];
  assign IF_ID_Func    = instr_q[5:0];
  assign IF_ID_Imm     = instr_q[15:0];

  assign flush   = BranchTaken | JumpTaken;
  assign uses_rt = (IF_ID_Opcode == OP_RTYPE) || (IF_ID_Opcode == OP_BEQ) ||
                   (IF_ID_Opcode == OP_BNE)   || (IF_ID_Opcode == OP_SW);

  // $0 is never a real dependency, so a load into $0 cannot stall.
  assign hazard = valid_q && ID_EXE_MemRead && (ID_EXE_RtAddr != 5'd0) &&
                  ((ID_EXE_RtAddr == IF_ID_RsAddr) ||
                   (uses_rt && (ID_EXE_RtAddr == IF_ID_RtAddr)));

  assign stall_run = hazard && (state_q == ST_RUN);
  // A redirect discards the stalled instruction, so the PC must advance.
  assign PCWrite   = !(stall_run && !flush);
  assign Bubble    = stall_run || !valid_q;

  // Next-state logic.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path
    // leaves it unassigned and infers a latch.
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      ST_RUN: begin
        if (flush) begin
          state_d = (CNT_LOAD != 2'd0) ? ST_FLUSH : ST_RUN;
          cnt_d   = CNT_LOAD;
        end else if (hazard) begin
          state_d = ST_LDSTALL;
        end
      end
      ST_LDSTALL: begin
        if (flush) begin
          state_d = (CNT_LOAD != 2'd0) ? ST_FLUSH : ST_RUN;
          cnt_d   = CNT_LOAD;
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_FLUSH: begin
        if (flush) begin
          state_d = (CNT_LOAD != 2'd0) ? ST_FLUSH : ST_RUN;
          cnt_d   = CNT_LOAD;
        end else begin
          cnt_d = cnt_q - 2'd1;
          if (cnt_q <= 2'd1) begin
            state_d = ST_RUN;
            cnt_d   = 2'd0;
          end
        end
      end
      default: begin
        state_d = ST_RUN;
        cnt_d   = 2'd0;
      end
    endcase
  end

  // Pipeline register next values, highest priority first.
  always_comb begin
    instr_d   = instr_q;
    pcplus4_d = pcplus4_q;
    valid_d   = valid_q;
    if (flush || (state_q == ST_FLUSH)) begin
      instr_d   = 32'd0;
      pcplus4_d = PCplus4In;
      valid_d   = 1'b0;
    end else if (!stall_run) begin
      instr_d   = InstrIn;
      pcplus4_d = PCplus4In;
      valid_d   = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: sequential state uses non-blocking assignments so every flop
      // samples pre-edge values regardless of statement order.
      state_q   <= ST_RUN;
      cnt_q     <= 2'd0;
      instr_q   <= 32'd0;
      pcplus4_q <= 32'd0;
      valid_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      instr_q   <= instr_d;
      pcplus4_q <= pcplus4_d;
      valid_q   <= valid_d;
    end
  end

`ifdef HAZARD_STATS_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;
  logic [31:0] flush_cnt_q, flush_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (!PCWrite && (stall_cnt_q != 32'hFFFF_FFFF)) stall_cnt_d = stall_cnt_q + 32'd1;
    if (flush && (flush_cnt_q != 32'hFFFF_FFFF))    flush_cnt_d = flush_cnt_q + 32'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_q <= 32'd0;
      flush_cnt_q <= 32'd0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign StallCount = stall_cnt_q;
  assign FlushCount = flush_cnt_q;
`endif

endmodule

// File: tb/tb_if_id_stage.sv
// ---------------------------------------------------------------------------
// tb_if_id_stage
//
// Directed self-checking bench for if_id_stage with FLUSH_CYCLES=2.
// Inputs change 1 ns after the rising edge; outputs are sampled in the same
// low-activity window, well away from the next edge.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_if_id_stage;

  localparam logic [31:0] ADD_9_10 = 32'h012A_4020; // add $8,$9,$10

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] InstrIn, PCplus4In;
  logic        ID_EXE_MemRead;
  logic [4:0]  ID_EXE_RtAddr;
  logic        BranchTaken, JumpTaken;
  logic [31:0] IF_ID_Instr, IF_ID_PCplus4;
  logic [5:0]  IF_ID_Opcode, IF_ID_Func;
  logic [4:0]  IF_ID_RsAddr, IF_ID_RtAddr, IF_ID_Rd, IF_ID_Shamt;
  logic [15:0] IF_ID_Imm;
  logic        IF_ID_Valid, PCWrite, Bubble;
`ifdef HAZARD_STATS_EN
  logic [31:0] StallCount, FlushCount;
`endif

  int checks = 0;
  int errors = 0;

  if_id_stage #(.FLUSH_CYCLES(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .InstrIn(InstrIn), .PCplus4In(PCplus4In),
    .ID_EXE_MemRead(ID_EXE_MemRead), .ID_EXE_RtAddr(ID_EXE_RtAddr),
    .BranchTaken(BranchTaken), .JumpTaken(JumpTaken),
    .IF_ID_Instr(IF_ID_Instr), .IF_ID_PCplus4(IF_ID_PCplus4),
    .IF_ID_Opcode(IF_ID_Opcode), .IF_ID_RsAddr(IF_ID_RsAddr),
    .IF_ID_RtAddr(IF_ID_RtAddr), .IF_ID_Rd(IF_ID_Rd),
    .IF_ID_Shamt(IF_ID_Shamt), .IF_ID_Func(IF_ID_Func),
    .IF_ID_Imm(IF_ID_Imm), .IF_ID_Valid(IF_ID_Valid),
    .PCWrite(PCWrite), .Bubble(Bubble)
`ifdef HAZARD_STATS_EN
    , .StallCount(StallCount), .FlushCount(FlushCount)
`endif
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; InstrIn = '0; PCplus4In = '0; ID_EXE_MemRead = 1'b0;
    ID_EXE_RtAddr = '0; BranchTaken = 1'b0; JumpTaken = 1'b0;
    #3;
    checks++; if (IF_ID_Instr !== 32'd0) begin errors++; $display("FAIL reset_instr got %h exp %h", IF_ID_Instr, 32'd0); end
    checks++; if (IF_ID_PCplus4 !== 32'd0) begin errors++; $display("FAIL reset_pc4 got %h exp %h", IF_ID_PCplus4, 32'd0); end
    checks++; if (IF_ID_Valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", IF_ID_Valid); end
    checks++; if (PCWrite !== 1'b1) begin errors++; $display("FAIL reset_pcwrite got %b exp 1", PCWrite); end
    checks++; if (Bubble !== 1'b1) begin errors++; $display("FAIL reset_bubble got %b exp 1", Bubble); end
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  task automatic test_stream();
    InstrIn = ADD_9_10; PCplus4In = 32'h4;
    step();
    checks++; if (IF_ID_Instr !== ADD_9_10) begin errors++; $display("FAIL stream_instr got %h exp %h", IF_ID_Instr, ADD_9_10); end
    checks++; if (IF_ID_PCplus4 !== 32'h4) begin errors++; $display("FAIL stream_pc4 got %h exp 4", IF_ID_PCplus4); end
    checks++; if (IF_ID_Opcode !== 6'd0) begin errors++; $display("FAIL stream_opcode got %0d exp 0", IF_ID_Opcode); end
    checks++; if (IF_ID_RsAddr !== 5'd9) begin errors++; $display("FAIL stream_rs got %0d exp 9", IF_ID_RsAddr); end
    checks++; if (IF_ID_RtAddr !== 5'd10) begin errors++; $display("FAIL stream_rt got %0d exp 10", IF_ID_RtAddr); end
    checks++; if (IF_ID_Rd !== 5'd8) begin errors++; $display("FAIL stream_rd got %0d exp 8", IF_ID_Rd); end
    checks++; if (IF_ID_Shamt !== 5'd0) begin errors++; $display("FAIL stream_shamt got %0d exp 0", IF_ID_Shamt); end
    checks++; if (IF_ID_Func !== 6'h20) begin errors++; $display("FAIL stream_func got %h exp 20", IF_ID_Func); end
    checks++; if (IF_ID_Imm !== 16'h4020) begin errors++; $display("FAIL stream_imm got %h exp 4020", IF_ID_Imm); end
    checks++; if (IF_ID_Valid !== 1'b1) begin errors++; $display("FAIL stream_valid got %b exp 1", IF_ID_Valid); end
    checks++; if (PCWrite !== 1'b1) begin errors++; $display("FAIL stream_pcwrite got %b exp 1", PCWrite); end
    checks++; if (Bubble !== 1'b0) begin errors++; $display("FAIL stream_bubble got %b exp 0", Bubble); end
  endtask

  task automatic test_load_use_rs();
    InstrIn = 32'h8C0B_0000; PCplus4In = 32'h8;
    ID_EXE_MemRead = 1'b1; ID_EXE_RtAddr = 5'd9;
    #1;
    checks++; if (PCWrite !== 1'b0) begin errors++; $display("FAIL lu_rs_pcwrite got %b exp 0", PCWrite); end
    checks++; if (Bubble !== 1'b1) begin errors++; $display("FAIL lu_rs_bubble got %b exp 1", Bubble); end
    step();
    ID_EXE_MemRead = 1'b0;
    #1;
    checks++; if (IF_ID_Instr !== ADD_9_10) begin errors++; $display("FAIL lu_rs_hold_instr got %h exp %h", IF_ID_Instr, ADD_9_10); end
    checks++; if (IF_ID_PCplus4 !== 32'h4) begin errors++; $display("FAIL lu_rs_hold_pc4 got %h exp 4", IF_ID_PCplus4); end
    checks++; if (PCWrite !== 1'b1) begin errors++; $display("FAIL lu_rs_resume_pcwrite got %b exp 1", PCWrite); end
    checks++; if (Bubble !== 1'b0) begin errors++; $display("FAIL lu_rs_resume_bubble got %b exp 0", Bubble); end
    step();
    checks++; if (IF_ID_Instr !== 32'h8C0B_0000) begin errors++; $display("FAIL lu_rs_next_instr got %h exp 8c0b0000", IF_ID_Instr); end
    checks++; if (IF_ID_PCplus4 !== 32'h8) begin errors++; $display("FAIL lu_rs_next_pc4 got %h exp 8", IF_ID_PCplus4); end
  endtask

  task automatic test_rt_nonuser();
    InstrIn = 32'h2065_0007; PCplus4In = 32'hC; // addi $5,$3,7
    step();
    checks++; if (IF_ID_Opcode !== 6'd8) begin errors++; $display("FAIL addi_opcode got %0d exp 8", IF_ID_Opcode); end
    ID_EXE_MemRead = 1'b1; ID_EXE_RtAddr = 5'd5;
    #1;
    checks++; if (PCWrite !== 1'b1) begin errors++; $display("FAIL addi_rt_pcwrite got %b exp 1", PCWrite); end
    checks++; if (Bubble !== 1'b0) begin errors++; $display("FAIL addi_rt_bubble got %b exp 0", Bubble); end
    ID_EXE_MemRead = 1'b0; InstrIn = 32'h2005_0007; PCplus4In = 32'h10; // addi $5,$0,7
    step();
    ID_EXE_MemRead = 1'b1; ID_EXE_RtAddr = 5'd0;
    #1;
    checks++; if (PCWrite !== 1'b1) begin errors++; $display("FAIL zero_reg_pcwrite got %b exp 1", PCWrite); end
    ID_EXE_MemRead = 1'b0; InstrIn = 32'hAC65_0000; PCplus4In = 32'h14; // sw $5,0($3)
    step();
    ID_EXE_MemRead = 1'b1; ID_EXE_RtAddr = 5'd5;
    #1;
    checks++; if (PCWrite !== 1'b0) begin errors++; $display("FAIL sw_rt_pcwrite got %b exp 0", PCWrite); end
    ID_EXE_MemRead = 1'b0;
    #1;
    checks++; if (PCWrite !== 1'b1) begin errors++; $display("FAIL sw_clear_pcwrite got %b exp 1", PCWrite); end
  endtask

  task automatic test_branch_flush();
    BranchTaken = 1'b1; InstrIn = 32'h1111_1111; PCplus4In = 32'h20;
    step();
    BranchTaken = 1'b0; InstrIn = 32'h2222_2222; PCplus4In = 32'h24;
    #1;
    checks++; if (IF_ID_Instr !== 32'd0) begin errors++; $display("FAIL br_slot1_instr got %h exp 0", IF_ID_Instr); end
    checks++; if (IF_ID_PCplus4 !== 32'h20) begin errors++; $display("FAIL br_slot1_pc4 got %h exp 20", IF_ID_PCplus4); end
    checks++; if (IF_ID_Valid !== 1'b0) begin errors++; $display("FAIL br_slot1_valid got %b exp 0", IF_ID_Valid); end
    checks++; if (Bubble !== 1'b1) begin errors++; $display("FAIL br_slot1_bubble got %b exp 1", Bubble); end
    step();
    InstrIn = 32'h3333_3333; PCplus4In = 32'h28;
    #1;
    checks++; if (IF_ID_Instr !== 32'd0) begin errors++; $display("FAIL br_slot2_instr got %h exp 0", IF_ID_Instr); end
    checks++; if (IF_ID_Valid !== 1'b0) begin errors++; $display("FAIL br_slot2_valid got %b exp 0", IF_ID_Valid); end
    checks++; if (Bubble !== 1'b1) begin errors++; $display("FAIL br_slot2_bubble got %b exp 1", Bubble); end
    step();
    checks++; if (IF_ID_Instr !== 32'h3333_3333) begin errors++; $display("FAIL br_resume_instr got %h exp 33333333", IF_ID_Instr); end
    checks++; if (IF_ID_Valid !== 1'b1) begin errors++; $display("FAIL br_resume_valid got %b exp 1", IF_ID_Valid); end
    checks++; if (Bubble !== 1'b0) begin errors++; $display("FAIL br_resume_bubble got %b exp 0", Bubble); end
  endtask

  task automatic test_hazard_and_jump();
    InstrIn = ADD_9_10; PCplus4In = 32'h30;
    step();
    ID_EXE_MemRead = 1'b1; ID_EXE_RtAddr = 5'd9; JumpTaken = 1'b1;
    InstrIn = 32'h4444_4444; PCplus4In = 32'h34;
    #1;
    checks++; if (PCWrite !== 1'b1) begin errors++; $display("FAIL hj_pcwrite got %b exp 1", PCWrite); end
    checks++; if (Bubble !== 1'b1) begin errors++; $display("FAIL hj_bubble got %b exp 1", Bubble); end
    step();
    JumpTaken = 1'b0; ID_EXE_MemRead = 1'b0; InstrIn = 32'h5555_5555; PCplus4In = 32'h38;
    #1;
    checks++; if (IF_ID_Instr !== 32'd0) begin errors++; $display("FAIL hj_nop_instr got %h exp 0", IF_ID_Instr); end
    checks++; if (IF_ID_PCplus4 !== 32'h34) begin errors++; $display("FAIL hj_nop_pc4 got %h exp 34", IF_ID_PCplus4); end
    step();
    // A second squashed slot proves FLUSH was entered rather than LDSTALL.
    checks++; if (IF_ID_Instr !== 32'd0) begin errors++; $display("FAIL hj_flush_state_instr got %h exp 0", IF_ID_Instr); end
    InstrIn = 32'h6666_6666; PCplus4In = 32'h3C;
    step();
    checks++; if (IF_ID_Instr !== 32'h6666_6666) begin errors++; $display("FAIL hj_resume_instr got %h exp 66666666", IF_ID_Instr); end
    checks++; if (IF_ID_Valid !== 1'b1) begin errors++; $display("FAIL hj_resume_valid got %b exp 1", IF_ID_Valid); end
  endtask

  task automatic test_reset_mid_stall();
    InstrIn = ADD_9_10; PCplus4In = 32'h40;
    step();
    ID_EXE_MemRead = 1'b1; ID_EXE_RtAddr = 5'd9;
    #1;
    checks++; if (PCWrite !== 1'b0) begin errors++; $display("FAIL mid_stall_pcwrite got %b exp 0", PCWrite); end
    rst_n = 1'b0;
    #1;
    checks++; if (IF_ID_Instr !== 32'd0) begin errors++; $display("FAIL rst_stall_instr got %h exp 0", IF_ID_Instr); end
    checks++; if (IF_ID_PCplus4 !== 32'd0) begin errors++; $display("FAIL rst_stall_pc4 got %h exp 0", IF_ID_PCplus4); end
    checks++; if (IF_ID_RsAddr !== 5'd0) begin errors++; $display("FAIL rst_stall_rs got %0d exp 0", IF_ID_RsAddr); end
    checks++; if (IF_ID_Valid !== 1'b0) begin errors++; $display("FAIL rst_stall_valid got %b exp 0", IF_ID_Valid); end
    checks++; if (PCWrite !== 1'b1) begin errors++; $display("FAIL rst_stall_pcwrite got %b exp 1", PCWrite); end
    checks++; if (Bubble !== 1'b1) begin errors++; $display("FAIL rst_stall_bubble got %b exp 1", Bubble); end
`ifdef HAZARD_STATS_EN
    checks++; if (StallCount !== 32'd0) begin errors++; $display("FAIL rst_stallcount got %0d exp 0", StallCount); end
    checks++; if (FlushCount !== 32'd0) begin errors++; $display("FAIL rst_flushcount got %0d exp 0", FlushCount); end
`endif
    ID_EXE_MemRead = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

`ifdef HAZARD_STATS_EN
  task automatic test_stats();
    for (int i = 0; i < 3; i++) begin
      InstrIn = ADD_9_10; PCplus4In = 32'h50;
      step();
      ID_EXE_MemRead = 1'b1; ID_EXE_RtAddr = 5'd9;
      step();
      ID_EXE_MemRead = 1'b0;
      step();
    end
    checks++; if (StallCount !== 32'd3) begin errors++; $display("FAIL stats_stallcount got %0d exp 3", StallCount); end
    checks++; if (FlushCount !== 32'd0) begin errors++; $display("FAIL stats_flush_idle got %0d exp 0", FlushCount); end
    BranchTaken = 1'b1;
    step();
    BranchTaken = 1'b0;
    #1;
    checks++; if (FlushCount !== 32'd1) begin errors++; $display("FAIL stats_flushcount got %0d exp 1", FlushCount); end
    step();
    step();
  endtask
`endif

  initial begin
    test_reset();
    test_stream();
    test_load_use_rs();
    test_rt_nonuser();
    test_branch_flush();
    test_hazard_and_jump();
    test_reset_mid_stall();
`ifdef HAZARD_STATS_EN
    test_stats();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
